// File: rtl/masked_sbox_lanes_pkg.sv
// Shared definitions for the masked S-box lanes: affine constants, randomness sizing
// and GF(2^8) helpers over the AES polynomial x^8 + x^4 + x^3 + x + 1.
package masked_sbox_lanes_pkg;

  localparam logic [7:0] AFFINE_FWD_C = 8'h63;
  localparam logic [7:0] AFFINE_INV_C = 8'h05;

  // One share of a masked byte; a lane carries NUM_SHARES of these packed together.
  typedef logic [7:0] share_byte_t;

  function automatic int unsigned num_dom_pairs(int unsigned ns);
    return ns * (ns - 1) / 2;
  endfunction

  // Four multiplier stages, one fresh byte per unordered share pair each.
  function automatic int unsigned num_4stage_inv_random(int unsigned ns);
    return 4 * 8 * num_dom_pairs(ns);
  endfunction

  function automatic int unsigned num_sbox_lanes_random(int unsigned ns, int unsigned nl);
    return nl * num_4stage_inv_random(ns);
  endfunction

  function automatic int unsigned dom_pair_idx(int unsigned ns, int unsigned i, int unsigned j);
    int unsigned lo;
    int unsigned hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * ns - lo * (lo + 1) / 2 + (hi - lo - 1);
  endfunction

  function automatic share_byte_t gf_mul(share_byte_t a, share_byte_t b);
    share_byte_t p;
    share_byte_t t;
    p = '0;
    t = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p ^= t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^(2^n): squaring is linear, so it can be applied share by share.
  function automatic share_byte_t gf_sq_n(share_byte_t a, int unsigned n);
    share_byte_t y;
    y = a;
    for (int unsigned k = 0; k < n; k++) y = gf_mul(y, y);
    return y;
  endfunction

  function automatic share_byte_t rotl8(share_byte_t x, int unsigned n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

endpackage

// File: rtl/masked_bv8_affine.sv
// Masked AES affine transform: linear part on every share, constant folded into share 0.
module masked_bv8_affine import masked_sbox_lanes_pkg::*; #(
  parameter int unsigned NUM_SHARES = 2,
  parameter bit          INVERSE    = 1'b0
) (
  input  logic [NUM_SHARES*8-1:0] in_a,
  output logic [NUM_SHARES*8-1:0] out_b
);

  localparam share_byte_t AffineC = INVERSE ? AFFINE_INV_C : AFFINE_FWD_C;

  for (genvar s = 0; s < NUM_SHARES; s++) begin : g_share
    share_byte_t x;
    share_byte_t lin;
    assign x = in_a[s*8 +: 8];
    if (INVERSE) begin : g_inv
      assign lin = rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6);
    end else begin : g_fwd
      assign lin = x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4);
    end
    assign out_b[s*8 +: 8] = (s == 0) ? (lin ^ AffineC) : lin;
  end

endmodule

// File: rtl/masked_sbox_lanes.sv
// Multi-lane masked AES S-box: 4-stage masked inverter (x^254 via four DOM multiplies)
// with shared valid/mode control, randomness policing and output gating.
module masked_sbox_lanes import masked_sbox_lanes_pkg::*; #(
  parameter int unsigned NUM_SHARES = 2,
  parameter int unsigned NUM_LANES  = 4
) (
  input  logic                                                in_clock,
  input  logic                                                in_reset,
  input  logic                                                in_valid,
  output logic                                                in_ready,
  input  logic                                                in_inverse,
  input  logic [NUM_LANES*NUM_SHARES*8-1:0]                   in_a,
  input  logic [num_sbox_lanes_random(NUM_SHARES, NUM_LANES)-1:0] in_random,
  input  logic                                                in_random_valid,
  input  logic                                                in_clear,
  output logic [NUM_LANES*NUM_SHARES*8-1:0]                   out_b,
  output logic                                                out_valid,
  output logic                                                out_busy,
  output logic [2:0]                                          out_in_flight,
  output logic                                                out_rand_error
);

  localparam int unsigned LaneW      = NUM_SHARES * 8;
  localparam int unsigned StageRandW = num_dom_pairs(NUM_SHARES) * 8;
  localparam int unsigned LaneRandW  = num_4stage_inv_random(NUM_SHARES);

  typedef share_byte_t [NUM_SHARES-1:0] lane_shares_t;

  function automatic lane_shares_t sq_n(lane_shares_t x, int unsigned n);
    lane_shares_t y;
    for (int unsigned s = 0; s < NUM_SHARES; s++) y[s] = gf_sq_n(x[s], n);
    return y;
  endfunction

  // Cross products are blinded by one byte per share pair; each byte appears twice and cancels.
  function automatic lane_shares_t dom_mul(lane_shares_t x, lane_shares_t y,
                                           logic [StageRandW-1:0] r);
    lane_shares_t z;
    for (int unsigned i = 0; i < NUM_SHARES; i++) begin
      z[i] = gf_mul(x[i], y[i]);
      for (int unsigned j = 0; j < NUM_SHARES; j++) begin
        if (j != i) begin
          z[i] ^= gf_mul(x[i], y[j]) ^ share_byte_t'(r >> (dom_pair_idx(NUM_SHARES, i, j) * 8));
        end
      end
    end
    return z;
  endfunction

  logic [3:0] valid_q, valid_d, mode_q;
  logic       rand_err_q, rand_err_d;
  logic       accept, rand_drop;

  assign accept    = in_valid & in_random_valid;
  assign rand_drop = ~in_random_valid & out_busy;

  always_comb begin
    valid_d    = {valid_q[2:0], accept};
    rand_err_d = rand_err_q | rand_drop;
    if (in_clear) begin
      valid_d    = '0;
      rand_err_d = 1'b0;
    end else if (rand_drop) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      valid_q    <= '0;
      mode_q     <= '0;
      rand_err_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      mode_q     <= {mode_q[2:0], in_inverse};
      rand_err_q <= rand_err_d;
    end
  end

  assign in_ready       = in_random_valid;
  assign out_valid      = valid_q[3];
  assign out_busy       = |valid_q;
  assign out_in_flight  = 3'(valid_q[0]) + 3'(valid_q[1]) + 3'(valid_q[2]) + 3'(valid_q[3]);
  assign out_rand_error = rand_err_q;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [LaneW-1:0]     a_raw, a_pre, b_post;
    logic [LaneRandW-1:0] rnd;
    lane_shares_t         x0, b_sel;
    lane_shares_t         s1_p, s1_x, s2_p, s2_x3, s2_x, s3_p, s3_x, s4_p;

    assign a_raw = in_a[l*LaneW +: LaneW];
    assign rnd   = in_random[l*LaneRandW +: LaneRandW];

    masked_bv8_affine #(.NUM_SHARES(NUM_SHARES), .INVERSE(1'b1)) u_pre_affine (
      .in_a  (a_raw),
      .out_b (a_pre)
    );

    assign x0 = in_inverse ? a_pre : a_raw;

    // Addition chain: x^3, x^15, x^252 = x^240 * x^12, x^254 = x^252 * x^2.
    always_ff @(posedge in_clock or negedge in_reset) begin
      if (!in_reset) begin
        s1_p  <= '0;
        s1_x  <= '0;
        s2_p  <= '0;
        s2_x3 <= '0;
        s2_x  <= '0;
        s3_p  <= '0;
        s3_x  <= '0;
        s4_p  <= '0;
      end else begin
        s1_p  <= dom_mul(sq_n(x0, 1), x0, rnd[0 +: StageRandW]);
        s1_x  <= x0;
        s2_p  <= dom_mul(sq_n(s1_p, 2), s1_p, rnd[StageRandW +: StageRandW]);
        s2_x3 <= s1_p;
        s2_x  <= s1_x;
        s3_p  <= dom_mul(sq_n(s2_p, 4), sq_n(s2_x3, 2), rnd[2*StageRandW +: StageRandW]);
        s3_x  <= s2_x;
        s4_p  <= dom_mul(s3_p, sq_n(s3_x, 1), rnd[3*StageRandW +: StageRandW]);
      end
    end

    masked_bv8_affine #(.NUM_SHARES(NUM_SHARES), .INVERSE(1'b0)) u_post_affine (
      .in_a  (s4_p),
      .out_b (b_post)
    );

    assign b_sel                    = mode_q[3] ? s4_p : lane_shares_t'(b_post);
    assign out_b[l*LaneW +: LaneW] = b_sel & {LaneW{out_valid}};
  end

endmodule

// File: tb/tb_masked_sbox_lanes.sv
// Scoreboard bench for masked_sbox_lanes: randomly masked stimulus, table-based S-box model.
module tb_masked_sbox_lanes;
  import masked_sbox_lanes_pkg::*;

  localparam int unsigned NS = 2;
  localparam int unsigned NL = 4;
  localparam int unsigned RW = num_sbox_lanes_random(NS, NL);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0, in_inverse = 1'b0, in_random_valid = 1'b0, in_clear = 1'b0;
  logic [NL*NS*8-1:0] in_a = '0;
  logic [RW-1:0]   in_random = '0;
  logic            in_ready, out_valid, out_busy, out_rand_error;
  logic [NL*NS*8-1:0] out_b;
  logic [2:0]      out_in_flight;

  masked_sbox_lanes #(.NUM_SHARES(NS), .NUM_LANES(NL)) dut (
    .in_clock        (clk),
    .in_reset        (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_inverse      (in_inverse),
    .in_a            (in_a),
    .in_random       (in_random),
    .in_random_valid (in_random_valid),
    .in_clear        (in_clear),
    .out_b           (out_b),
    .out_valid       (out_valid),
    .out_busy        (out_busy),
    .out_in_flight   (out_in_flight),
    .out_rand_error  (out_rand_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] exp;
    int          due;
  } ent_t;

  ent_t        sb[$];
  logic [7:0]  sbox[256];
  logic [7:0]  inv_sbox[256];
  logic [31:0] cur_exp = '0;
  bit          model_err = 1'b0;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_mul(logic [7:0] a, logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= 16'(a) << i;
    for (int i = 15; i >= 8; i--) if (p[i]) p ^= 16'h011b << (i - 8);
    return p[7:0];
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++) begin
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
             ^ inv[(i + 7) % 8] ^ c[i];
      end
      sbox[x]     = s;
      inv_sbox[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] ref_word(logic [31:0] x, bit inv);
    logic [31:0] r;
    for (int l = 0; l < NL; l++) r[l*8 +: 8] = inv ? inv_sbox[x[l*8 +: 8]] : sbox[x[l*8 +: 8]];
    return r;
  endfunction

  function automatic logic [31:0] unmask(logic [NL*NS*8-1:0] b);
    logic [31:0] r;
    for (int l = 0; l < NL; l++) r[l*8 +: 8] = b[l*16 +: 8] ^ b[l*16 + 8 +: 8];
    return r;
  endfunction

  task automatic step(input bit v, input bit inv, input logic [31:0] x, input logic [31:0] exp,
                      input bit rv, input bit clr);
    logic [7:0] m;
    @(posedge clk);
    #1;
    in_valid        = v;
    in_inverse      = inv;
    in_random_valid = rv;
    in_clear        = clr;
    cur_exp         = exp;
    for (int l = 0; l < NL; l++) begin
      m = 8'($urandom);
      in_a[l*16 +: 8]     = x[l*8 +: 8] ^ m;
      in_a[l*16 + 8 +: 8] = m;
    end
    for (int k = 0; k < int'(RW / 32); k++) in_random[k*32 +: 32] = $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic accept_rand(input bit inv);
    logic [31:0] x;
    x = $urandom;
    step(1'b1, inv, x, ref_word(x, inv), 1'b1, 1'b0);
  endtask

  // Reference: every in-flight transaction is lost on clear, randomness drop or reset.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      if (in_clear) begin
        sb.delete();
        model_err = 1'b0;
      end else if (!in_random_valid && sb.size() > 0) begin
        sb.delete();
        model_err = 1'b1;
      end else if (in_valid && in_random_valid) begin
        sb.push_back('{exp: cur_exp, due: cyc + 3});
      end
    end
  end

  initial forever begin
    @(negedge rst_n);
    sb.delete();
    model_err = 1'b0;
  end

  initial forever begin
    ent_t e;
    @(negedge clk);
    if (rst_n) begin
      check("in_ready", 64'(in_ready), 64'(in_random_valid));
      check("in_flight", 64'(out_in_flight), 64'(sb.size()));
      check("busy", 64'(out_busy), 64'(sb.size() > 0));
      check("rand_error", 64'(out_rand_error), 64'(model_err));
      if (out_valid) begin
        check("output_expected", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("latency", 64'(cyc), 64'(e.due));
          check("result", 64'(unmask(out_b)), 64'(e.exp));
        end
      end else begin
        check("gated_zero", 64'(out_b), 64'd0);
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          check("missing_output", 64'(out_valid), 64'd1);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    logic [31:0] x;
    bit          v, inv, rv, clr;
    build_tables();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_busy", 64'(out_busy), 64'd0);
    check("rst_in_flight", 64'(out_in_flight), 64'd0);
    check("rst_rand_error", 64'(out_rand_error), 64'd0);
    check("rst_out_b", 64'(out_b), 64'd0);

    // Forward anchors, then streaming so the in-flight count walks 1..4.
    step(1'b1, 1'b0, 32'hFF530100, 32'h16ED7C63, 1'b1, 1'b0);
    repeat (3) accept_rand(1'b0);
    idle(6);

    step(1'b1, 1'b1, 32'h16ED7C63, 32'hFF530100, 1'b1, 1'b0);
    idle(6);

    for (int i = 0; i < 8; i++) accept_rand(i[0]);
    idle(6);

    // Randomness withdrawn two cycles after an accept.
    accept_rand(1'b0);
    idle(1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    idle(6);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    idle(2);

    x = $urandom;
    step(1'b1, 1'b0, x, ref_word(x, 1'b0), 1'b0, 1'b0);
    idle(5);

    x = $urandom;
    step(1'b1, 1'b0, x, ref_word(x, 1'b0), 1'b1, 1'b1);
    idle(6);

    // Asynchronous reset with three transactions in flight.
    repeat (3) accept_rand(1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_out_busy", 64'(out_busy), 64'd0);
    check("arst_in_flight", 64'(out_in_flight), 64'd0);
    check("arst_rand_error", 64'(out_rand_error), 64'd0);
    check("arst_out_b", 64'(out_b), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    accept_rand(1'b0);
    idle(6);

    for (int i = 0; i < 300; i++) begin
      x   = $urandom;
      v   = ($urandom_range(0, 3) != 0);
      inv = 1'($urandom_range(0, 1));
      rv  = ($urandom_range(0, 19) != 0);
      clr = ($urandom_range(0, 39) == 0);
      step(v, inv, x, ref_word(x, inv), rv, clr);
    end
    idle(8);
    check("drain_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/masked_sbox_lanes.md
# masked_sbox_lanes

Parametrised, multi-lane masked AES S-box unit built around the 4-stage masked GF(2^8) inverter. It supports forward and inverse S-box per transaction and tracks transactions with valid, busy and in-flight signals. It also polices the randomness supply and flushes the pipeline if fresh randomness is interrupted while shares are in flight. It sits between the masked state/key datapath and the ShiftRows/MixColumns stage, and serves SubBytes and the key-schedule SubWord.

## Interface
- NUM_SHARES, 2: masking order + 1; ≥2.
- NUM_LANES, 4: parallel S-boxes; 1..16.
- in_clock  in  1  rising-edge clock.
- in_reset  in  1  asynchronous reset, active-low: clears all control state immediately.
- in_valid  in  1  transaction offered this cycle.
- in_ready  out  1  combinational; equals in_random_valid.
- in_inverse  in  1  0 = forward S-box, 1 = inverse S-box; sampled on accept.
- in_a  in  NUM_LANES×NUM_SHARES×8  shared input bytes.
- in_random  in  NUM_LANES×num_4stage_inv_random(NUM_SHARES)  fresh randomness; lane i uses slice i.
- in_random_valid  in  1  in_random is fresh this cycle.
- in_clear  in  1  synchronous flush.
- out_b  out  NUM_LANES×NUM_SHARES×8  shared output bytes; all-zero when out_valid=0.
- out_valid  out  1  out_b holds a result.
- out_busy  out  1  any transaction in flight.
- out_in_flight  out  3  in-flight count, 0..4.
- out_rand_error  out  1  sticky; randomness dropped while busy.

## Operation
- Accept: in_valid & in_random_valid. Without in_random_valid the input is dropped and nothing enters the pipeline.
- Inverse mode applies the masked inverse affine before the inverter. Forward mode applies the masked forward affine after it.
- Affine transforms are linear per share. The constant (0x63 forward, 0x05 inverse) is XORed into share 0 only.
- Per-lane input mux and output mux are selected by the mode bit carried for that transaction.
- Control pipeline: 4-deep valid shift register plus a parallel 4-deep mode shift register. It advances every cycle and never stalls.
- out_in_flight = popcount(valid[3:0]). out_busy = |valid.
- Randomness drop: if in_random_valid=0 while out_busy=1:
  - all valid bits clear on the next edge;
  - out_rand_error sets, and stays set until reset or in_clear.
  - Data registers are not cleared, but out_b is gated to zero because out_valid=0.
- in_clear: clears valid bits and out_rand_error on the next edge. It takes priority over a same-cycle accept, which is discarded.
- Same-cycle accept and randomness drop cannot occur, since accept requires in_random_valid=1.
- Output gating: out_b = inverter/affine result AND replicate(out_valid), per share.

## Timing
- Latency: exactly 4 cycles. A transaction accepted at edge k has out_valid=1 during the cycle after edge k+4.
- Throughput: 1 transaction per cycle; back-to-back accepts give consecutive out_valid cycles.
- Reset values: out_valid=0, out_busy=0, out_in_flight=0, out_rand_error=0, out_b=0.
- Reset assertion mid-operation drops all transactions immediately (asynchronous). The first accept after deassertion behaves as if from idle.
- in_ready is combinational from in_random_valid only, with no path from in_valid.

## Structure
- Shared package additions:
  - function num_sbox_lanes_random(NUM_SHARES, NUM_LANES) = NUM_LANES × num_4stage_inv_random(NUM_SHARES);
  - localparams AFFINE_FWD_C = 8'h63 and AFFINE_INV_C = 8'h05;
  - typedef for a shared byte vector per lane.
- One sub-module, masked_bv8_affine (parameters NUM_SHARES, INVERSE), instantiated twice per lane.
- Control logic lives in this module, shared across all lanes.

## Test plan
- Forward, NUM_SHARES=2, NUM_LANES=4:
  - lanes {0x00,0x01,0x53,0xFF} with random masks -> unmasked out {0x63,0x7C,0xED,0x16} at exactly +4 cycles;
  - out_in_flight counts 1,2,3,4 under streaming.
- Inverse mode: inputs {0x63,0x7C,0xED,0x16} -> {0x00,0x01,0x53,0xFF}.
- Alternating in_inverse on 8 back-to-back accepts -> each result matches its own mode, with out_valid high for 8 consecutive cycles.
- Randomness drop:
  - deassert in_random_valid 2 cycles after an accept -> no out_valid ever for that transaction;
  - out_rand_error=1 and persists; in_clear returns it to 0.
- in_valid=1 with in_random_valid=0 from idle -> in_ready=0, no output, no error.
- in_reset low mid-stream (3 in flight) -> all outputs 0 immediately; a new accept after release yields a correct result at +4.
